// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - sequential radix-2 multiplier with architectural HI/LO pair
//
// Purpose: computes 32x32 signed (MULT) / unsigned (MULTU) products one partial
// product per clock and services MTHI/MTLO writes. HI/LO feed write-back.
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   START       request strobe, sampled only in IDLE
//   OP[1:0]     00 MULT, 01 MULTU, 10 MTHI, 11 MTLO
//   OP_A, OP_B  multiplicand / multiplier (OP_A is write data for MTHI/MTLO)
//   BUSY        multiply in progress (RUN and FIX)
//   DONE        one-cycle completion pulse (FIN)
//   HI, LO      architectural result registers
module hilo_mult_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [1:0]        OP,
   input  logic [DATA_W-1:0] OP_A,
   input  logic [DATA_W-1:0] OP_B,
   output logic              BUSY,
   output logic              DONE,
   output logic [DATA_W-1:0] HI,
   output logic [DATA_W-1:0] LO
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_FIN} state_t;

   localparam logic [1:0]       OP_MULT   = 2'b00;
   localparam logic [1:0]       OP_MTHI   = 2'b10;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   state_t              state, state_nxt;
   logic [2*DATA_W:0]   acc;        // {carry, upper half, multiplier/low half}
   logic [DATA_W-1:0]   mcnd;
   logic                neg;
   logic [CNT_W-1:0]    cnt;

   logic                is_mul;
   logic                a_neg, b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W:0]     add_sum;
   logic [DATA_W:0]     acc_upper;
   logic [2*DATA_W:0]   acc_shift;
   logic [2*DATA_W-1:0] result;

   // Operands are reduced to unsigned magnitudes; the sign is reapplied in FIX.
   // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude.
   always_comb begin
      is_mul    = ~OP[1];
      a_neg     = (OP == OP_MULT) & OP_A[DATA_W-1];
      b_neg     = (OP == OP_MULT) & OP_B[DATA_W-1];
      a_mag     = a_neg ? (~OP_A + DATA_W'(1)) : OP_A;
      b_mag     = b_neg ? (~OP_B + DATA_W'(1)) : OP_B;
      add_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mcnd};
      acc_upper = acc[0] ? add_sum : acc[2*DATA_W:DATA_W];
      acc_shift = {1'b0, acc_upper, acc[DATA_W-1:1]};
      result    = neg ? (~acc[2*DATA_W-1:0] + (2*DATA_W)'(1)) : acc[2*DATA_W-1:0];
   end

   always_comb begin
      state_nxt = state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      case (state)
         S_IDLE: if (START) state_nxt = is_mul ? S_RUN : S_FIN;
         S_RUN: begin
            BUSY = 1'b1;
            if (cnt == LAST_ITER) state_nxt = S_FIX;
         end
         S_FIX: begin
            BUSY      = 1'b1;
            state_nxt = S_FIN;
         end
         S_FIN: begin
            DONE      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         acc   <= '0;
         mcnd  <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (START) begin
                  if (is_mul) begin
                     mcnd <= a_mag;
                     neg  <= a_neg ^ b_neg;
                     acc  <= {{(DATA_W+1){1'b0}}, b_mag};
                     cnt  <= '0;
                  end else if (OP == OP_MTHI) begin
                     HI <= OP_A;
                  end else begin
                     LO <= OP_A;
                  end
               end
            end
            S_RUN: begin
               acc <= acc_shift;
               cnt <= cnt + CNT_W'(1);
            end
            S_FIX: begin
               HI <= result[2*DATA_W-1:DATA_W];
               LO <= result[DATA_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb/tb_hilo_mult_unit.sv - self-checking bench for hilo_mult_unit
module tb_hilo_mult_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [1:0]  OP = 2'b00;
   logic [31:0] OP_A = '0;
   logic [31:0] OP_B = '0;
   logic        BUSY, DONE;
   logic [31:0] HI, LO;

   int checks = 0;
   int failures = 0;

   logic [63:0] sb[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   hilo_mult_unit dut (
      .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OP_A(OP_A), .OP_B(OP_B),
      .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
   );

   always #5 CLK = ~CLK;

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sbv;
      case (op)
         2'b00: begin
            sa  = $signed({{32{a[31]}}, a});
            sbv = $signed({{32{b[31]}}, b});
            return sa * sbv;
         end
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: return {a, m_lo};
         default: return {m_hi, a};
      endcase
   endfunction

   // Issues one request and records handshake behaviour for 40 cycles after
   // the START edge; k is the number of edges since the START edge.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int done_at, output int done_cnt, output int busy_cnt,
                         output int busy_first, output int overlap, output logic [63:0] got);
      done_at = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1; overlap = 0; got = 'x;
      sb.push_back(model(op, a, b));
      START = 1'b1; OP = op; OP_A = a; OP_B = b;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (BUSY) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = k;
         end
         if (DONE) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               got = {HI, LO};
            end
         end
         if (BUSY && DONE) overlap++;
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      checks++;
      if ({BUSY, DONE, HI, LO} !== 66'b0) begin
         failures++;
         $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected all zero", BUSY, DONE, HI, LO);
      end
      m_hi = '0; m_lo = '0;
   endtask

   task automatic mult_case(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
      int da, dc, bc, bf, ov;
      logic [63:0] got, exp;
      run_op(op, a, b, da, dc, bc, bf, ov, got);
      exp = sb.pop_front();
      m_hi = exp[63:32]; m_lo = exp[31:0];
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s result got=%h expected=%h", name, got, exp);
      end
      checks++;
      if (da != 33 || dc != 1 || bc != 33 || bf != 0 || ov != 0) begin
         failures++;
         $display("FAIL %s timing done_at=%0d done_cnt=%0d busy_cnt=%0d busy_first=%0d overlap=%0d expected 33/1/33/0/0",
                  name, da, dc, bc, bf, ov);
      end
   endtask

   task automatic test_multu_max();
      mult_case("multu_ffff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) begin
         failures++;
         $display("FAIL multu_ffff_const got=%h%h expected=fffffffe00000001", HI, LO);
      end
   endtask

   task automatic test_mult_signed();
      mult_case("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
      checks++;
      if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         failures++;
         $display("FAIL mult_m3x5_const got=%h%h expected=fffffffffffffff1", HI, LO);
      end
      mult_case("mult_m7xm6", 2'b00, -32'sd7, -32'sd6);
      checks++;
      if ({HI, LO} !== 64'h0000_0000_0000_002A) begin
         failures++;
         $display("FAIL mult_m7xm6_const got=%h%h expected=000000000000002a", HI, LO);
      end
      for (int i = 0; i < 4; i++) begin
         mult_case("mult_rand", 2'(i & 1), $urandom, $urandom);
      end
   endtask

   task automatic test_mult_boundary();
      mult_case("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
      mult_case("mult_min_one", 2'b00, 32'h8000_0000, 32'd1);
      checks++;
      if ({HI, LO} !== 64'hFFFF_FFFF_8000_0000) begin
         failures++;
         $display("FAIL mult_min_one_const got=%h%h expected=ffffffff80000000", HI, LO);
      end
      mult_case("mult_zero_neg", 2'b00, 32'd0, 32'hFFFF_FFFF);
   endtask

   task automatic test_start_ignored();
      int dc = 0;
      START = 1'b1; OP = 2'b01; OP_A = 32'd3; OP_B = 32'd4;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (DONE) dc++;
         START = (k == 9);
         OP = 2'b10; OP_A = 32'hDEAD_BEEF;
         @(posedge CLK); #1;
      end
      START = 1'b0;
      m_hi = 32'd0; m_lo = 32'd12;
      checks++;
      if ({HI, LO} !== 64'd12 || dc != 1) begin
         failures++;
         $display("FAIL start_ignored hi=%h lo=%h done_cnt=%0d expected hi=0 lo=c done_cnt=1", HI, LO, dc);
      end
   endtask

   task automatic test_reset_abort();
      START = 1'b1; OP = 2'b00; OP_A = 32'd1234; OP_B = 32'd5678;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(posedge CLK); #1;
      end
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      m_hi = '0; m_lo = '0;
      checks++;
      if ({BUSY, DONE, HI, LO} !== 66'b0) begin
         failures++;
         $display("FAIL reset_abort busy=%b done=%b hi=%h lo=%h expected all zero", BUSY, DONE, HI, LO);
      end
      mult_case("multu_2x3_after_rst", 2'b01, 32'd2, 32'd3);
      checks++;
      if (LO !== 32'd6) begin
         failures++;
         $display("FAIL after_rst_lo got=%h expected=6", LO);
      end
   endtask

   task automatic test_back_to_back();
      int da, dc, bc, bf, ov;
      logic [63:0] got, exp;
      int busy_seen = 0;
      run_op(2'b10, 32'hAAAA_5555, 32'h0, da, dc, bc, bf, ov, got);
      exp = sb.pop_front();
      m_hi = exp[63:32]; m_lo = exp[31:0];
      checks++;
      if (got !== exp || da != 0 || dc != 1 || bc != 0) begin
         failures++;
         $display("FAIL mthi got=%h exp=%h done_at=%0d done_cnt=%0d busy_cnt=%0d", got, exp, da, dc, bc);
      end
      // MTLO then an MTHI on the first IDLE cycle afterwards
      sb.push_back(model(2'b11, 32'h1234_5678, 32'h0));
      START = 1'b1; OP = 2'b11; OP_A = 32'h1234_5678;
      @(posedge CLK); #1;
      START = 1'b0;
      exp = sb.pop_front();
      m_hi = exp[63:32]; m_lo = exp[31:0];
      if (BUSY) busy_seen++;
      checks++;
      if ({HI, LO} !== exp || DONE !== 1'b1) begin
         failures++;
         $display("FAIL mtlo got=%h%h done=%b expected=%h done=1", HI, LO, DONE, exp);
      end
      @(posedge CLK); #1;
      if (BUSY) busy_seen++;
      checks++;
      if (DONE !== 1'b0) begin
         failures++;
         $display("FAIL mtlo_done_width done=%b expected=0", DONE);
      end
      sb.push_back(model(2'b10, 32'h0BAD_F00D, 32'h0));
      START = 1'b1; OP = 2'b10; OP_A = 32'h0BAD_F00D;
      @(posedge CLK); #1;
      START = 1'b0;
      exp = sb.pop_front();
      m_hi = exp[63:32]; m_lo = exp[31:0];
      if (BUSY) busy_seen++;
      checks++;
      if ({HI, LO} !== 64'h0BAD_F00D_1234_5678 || DONE !== 1'b1 || busy_seen != 0) begin
         failures++;
         $display("FAIL b2b_mthi got=%h%h done=%b busy_seen=%0d expected=0badf00d12345678 done=1 busy_seen=0",
                  HI, LO, DONE, busy_seen);
      end
      @(posedge CLK); #1;
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_mult_boundary();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Sequential multiply unit and architectural HI/LO register pair. It sits directly downstream of the ALU operand path and feeds HI/LO to the register-file write-back mux (MFHI/MFLO).
- Computes 32x32 signed (MULT) or unsigned (MULTU) products by iterative radix-2 shift-add, one partial product per clock. It also services MTHI/MTLO writes.
- Exposes a START/BUSY/DONE handshake so the control unit can stall on HI/LO hazards.

Parameters:
- DATA_W, 32: operand/register width. Only 32 is required and verified.
- CNT_W, 6: iteration counter width. Must hold DATA_W.

Ports:
- CLK  in  1: system clock. All state changes on the rising edge.
- RST  in  1: synchronous, active-high reset.
- START  in  1: request strobe, sampled only in IDLE.
- OP  in  2: operation select.
  - 00 = MULT (signed).
  - 01 = MULTU (unsigned).
  - 10 = MTHI.
  - 11 = MTLO.
- OP_A  in  32: multiplicand (MULT/MULTU) or write data (MTHI/MTLO).
- OP_B  in  32: multiplier (ignored for MTHI/MTLO).
- BUSY  out  1: multiply in progress.
- DONE  out  1: one-cycle pulse; HI/LO hold the result of the completed request.
- HI  out  32: architectural HI register.
- LO  out  32: architectural LO register.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, HI=0, LO=0, BUSY=0, DONE=0, internal accumulator and counter cleared. Reset has priority over everything, including a multiply in progress; the partial result is discarded.
- States: IDLE, RUN, FIX, FIN.
- IDLE, START=1, OP=MULT/MULTU:
  - Capture MCND = |OP_A| and MPLR = |OP_B| as unsigned 32-bit magnitudes. For MULTU, or non-negative operands, the raw value is used.
  - Capture NEG = OP_A[31]^OP_B[31] for MULT, 0 for MULTU.
  - Load 65-bit accumulator P = {1'b0, 32'b0, MPLR}, counter=0, go to RUN. BUSY=1 from the next cycle.
- IDLE, START=1, OP=MTHI/MTLO:
  - HI (or LO) <= OP_A on that edge; the other register is unchanged.
  - Go to FIN. BUSY stays 0.
- RUN, each edge:
  - If P[0]=1, then P[64:32] <= P[63:32]+MCND (33-bit sum including carry).
  - Then shift P right by 1 with zero fill.
  - counter++.
  - After the 32nd RUN edge, go to FIX.
- FIX, one edge:
  - Result R = NEG ? (~P[63:0]+1) : P[63:0].
  - HI <= R[63:32], LO <= R[31:0].
  - Go to FIN.
  - MULTU also passes through FIX so latency is fixed.
- FIN, one cycle: DONE=1, BUSY=0, next state IDLE.
- Latency:
  - MULT/MULTU: START edge at cycle 0. HI/LO updated at cycle 33 edge. DONE high during cycle 34 (counted in cycles after the START edge).
  - MTHI/MTLO: register updated at the START edge; DONE high the following cycle.
- BUSY is high in RUN and FIX only. HI/LO never show partial products; they change only at the FIX edge, the MTHI/MTLO edge, or reset.
- START while not in IDLE (RUN/FIX/FIN) is ignored. No queuing; the control unit must wait for DONE.
- Arithmetic boundaries:
  - |0x80000000| = 0x80000000 as an unsigned magnitude; no overflow.
  - The 64-bit product always fits; no overflow flag.
  - Zero operand: NEG may be 1, but negating 0 yields 0, so the result is 0.
- DONE and BUSY are never simultaneously 1.

Test Plan:
- MULTU with OP_A=0xFFFFFFFF, OP_B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. BUSY high for cycles 1-33, DONE pulse in cycle 34 only.
- MULT with OP_A=0xFFFFFFFD (-3), OP_B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT with OP_A=-7, OP_B=-6 -> HI=0, LO=0x0000002A.
- MULT with OP_A=0x80000000, OP_B=0x80000000 -> HI=0x40000000, LO=0. MULT with OP_A=0x80000000, OP_B=1 -> HI=0xFFFFFFFF, LO=0x80000000. MULT with OP_A=0, OP_B=-1 -> HI=LO=0.
- Start MULTU 3x4, then assert START with OP=MTHI, OP_A=0xDEADBEEF at cycle 10 -> ignored. Final HI=0, LO=12, exactly one DONE.
- Start MULT 1234x5678 and assert RST at cycle 12 -> next cycle BUSY=0, DONE=0, HI=LO=0. A fresh MULTU 2x3 then completes normally with LO=6 at the standard latency.
- MTLO with OP_A=0x12345678 after HI=0xAAAA5555 -> LO=0x12345678 on the START edge, HI unchanged, DONE high one cycle, BUSY never asserted. Back-to-back MTHI the next IDLE cycle is accepted.
